// File: rtl/div_pkg.sv
// Shared widths, sideband word and saturation limits for the signed
// divider wrapper.
package div_pkg;

   localparam int Z_WIDTH = 48;
   localparam int D_WIDTH = Z_WIDTH / 2;
   localparam int LAT     = D_WIDTH + 1;

   localparam logic [D_WIDTH-1:0] Q_MAX =
      {1'b0, {(D_WIDTH-1){1'b1}}};
   localparam logic [D_WIDTH-1:0] Q_MIN =
      {1'b1, {(D_WIDTH-1){1'b0}}};

   // Flags that travel alongside an operand
   // while the divider works on it.
   typedef struct packed {
      logic v;
      logic neg;
      logic zneg;
      logic dz;
      logic povf;
   } side_t;

   function automatic logic [Z_WIDTH-1:0] abs_z(
      input logic [Z_WIDTH-1:0] x
   );
      return x[Z_WIDTH-1] ? (~x + Z_WIDTH'(1)) : x;
   endfunction

   function automatic logic [D_WIDTH-1:0] abs_d(
      input logic [D_WIDTH-1:0] x
   );
      return x[D_WIDTH-1] ? (~x + D_WIDTH'(1)) : x;
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Operand, result and divider-side signals of the signed
// divider wrapper.
interface div_ctrl_if;
   import div_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic [Z_WIDTH-1:0] in_z;
   logic [D_WIDTH-1:0] in_d;

   logic               out_valid;
   logic               out_ready;
   logic [D_WIDTH-1:0] out_q;
   logic               out_dz;
   logic               out_ovf;

   logic               div_ena;
   logic [Z_WIDTH-1:0] div_z;
   logic [D_WIDTH-1:0] div_d;
   logic [D_WIDTH-1:0] div_q;

   modport slave (
      input  in_valid,
      input  in_z,
      input  in_d,
      input  out_ready,
      input  div_q,
      output in_ready,
      output out_valid,
      output out_q,
      output out_dz,
      output out_ovf,
      output div_ena,
      output div_z,
      output div_d
   );

   modport master (
      output in_valid,
      output in_z,
      output in_d,
      output out_ready,
      output div_q,
      input  in_ready,
      input  out_valid,
      input  out_q,
      input  out_dz,
      input  out_ovf,
      input  div_ena,
      input  div_z,
      input  div_d
   );

endinterface

// File: rtl/div_ctrl_dly.sv
// Enable-gated sideband delay line, latency-matched to the
// pipelined divider.
module div_ctrl_dly
   import div_pkg::*;
#(
   parameter int N = LAT
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  side_t din,
   output side_t dout
);

   side_t [N-1:0] line_q;
   side_t [N-1:0] line_d;

   always_comb begin
      line_d = line_q;
      if (en) begin
         line_d = {line_q[N-2:0], din};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q <= '0;
      end else begin
         line_q <= line_d;
      end
   end

   assign dout = line_q[N-1];

endmodule

// File: rtl/div_ctrl.sv
// Signed front/back end around the unsigned pipelined divider:
// magnitudes in, signed saturated truncating quotient out.
module div_ctrl
   import div_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   div_ctrl_if.slave bus
);

   logic               stall;
   logic               ena;
   logic [Z_WIDTH-1:0] mag_z;
   logic [D_WIDTH-1:0] mag_d;
   logic               dz;
   logic               povf;
   side_t              side_in;
   side_t              tail;

   logic               q_big;
   logic               sat;
   logic [D_WIDTH-1:0] q_sat;
   logic [D_WIDTH-1:0] q_neg;
   logic [D_WIDTH-1:0] q_o;
   logic               dz_o;
   logic               ovf_o;

   // The divider and the delay line share one
   // enable, so they stay aligned under stall.
   assign stall       = bus.out_valid & ~bus.out_ready;
   assign ena         = ~stall;
   assign bus.div_ena = ena;
   assign bus.in_ready = ena;

   always_comb begin
      mag_z = abs_z(bus.in_z);
      mag_d = abs_d(bus.in_d);
      dz    = (bus.in_d == '0);
      povf  = ~dz & ({1'b0, mag_z} >=
               {1'b0, mag_d, {D_WIDTH{1'b0}}});
      side_in = '{
         v:    bus.in_valid,
         neg:  bus.in_z[Z_WIDTH-1] ^ bus.in_d[D_WIDTH-1],
         zneg: bus.in_z[Z_WIDTH-1],
         dz:   dz,
         povf: povf
      };
   end

   assign bus.div_z = bus.in_valid ? mag_z : '0;
   assign bus.div_d = bus.in_valid ? mag_d : '0;

   div_ctrl_dly #(
      .N (LAT)
   ) u_dly (
      .clk  (clk),
      .rst  (rst),
      .en   (ena),
      .din  (side_in),
      .dout (tail)
   );

   always_comb begin
      q_sat = tail.neg ? Q_MIN : Q_MAX;
      q_big = tail.neg ? (bus.div_q > Q_MIN)
                       : (bus.div_q > Q_MAX);
      sat   = ~tail.dz & (tail.povf | q_big);
      q_neg = ~bus.div_q + D_WIDTH'(1);
      q_o   = '0;
      dz_o  = 1'b0;
      ovf_o = 1'b0;
      if (tail.v) begin
         unique case (1'b1)
            tail.dz: begin
               q_o  = tail.zneg ? Q_MIN : Q_MAX;
               dz_o = 1'b1;
            end
            sat: begin
               q_o   = q_sat;
               ovf_o = 1'b1;
            end
            default: begin
               q_o = tail.neg ? q_neg : bus.div_q;
            end
         endcase
      end
   end

   assign bus.out_valid = tail.v;
   assign bus.out_q     = q_o;
   assign bus.out_dz    = dz_o;
   assign bus.out_ovf   = ovf_o;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl with a behavioural divider and a
// scoreboard built on signed integer division.
module tb_div_ctrl;
   import div_pkg::*;

   typedef struct packed {
      logic               dz;
      logic               ovf;
      logic [D_WIDTH-1:0] q;
   } exp_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   ready_mode;
   exp_t expq[$];

   div_ctrl_if bus ();

   div_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the unsigned divider.
   logic [D_WIDTH-1:0] dpipe [LAT];

   function automatic logic [D_WIDTH-1:0] udiv(
      input logic [Z_WIDTH-1:0] z,
      input logic [D_WIDTH-1:0] d
   );
      logic [Z_WIDTH-1:0] q;
      if (d == '0) return '1;
      q = z / Z_WIDTH'(d);
      return q[D_WIDTH-1:0];
   endfunction

   always @(posedge clk) begin
      if (bus.div_ena) begin
         for (int i = LAT - 1; i > 0; i--)
            dpipe[i] <= dpipe[i-1];
         dpipe[0] <= udiv(bus.div_z, bus.div_d);
      end
   end

   assign bus.div_q = dpipe[LAT-1];

   function automatic exp_t ref_div(
      input longint z,
      input longint d
   );
      exp_t   r;
      longint qq;
      longint qmax;
      longint qmin;
      qmax = (longint'(1) <<< (D_WIDTH - 1)) - 1;
      qmin = -(longint'(1) <<< (D_WIDTH - 1));
      r = '0;
      if (d == 0) begin
         r.dz = 1'b1;
         r.q  = (z < 0) ? D_WIDTH'(qmin) : D_WIDTH'(qmax);
         return r;
      end
      qq = z / d;
      if (qq > qmax) begin
         r.ovf = 1'b1;
         r.q   = D_WIDTH'(qmax);
      end else if (qq < qmin) begin
         r.ovf = 1'b1;
         r.q   = D_WIDTH'(qmin);
      end else begin
         r.q = D_WIDTH'(qq);
      end
      return r;
   endfunction

   task automatic check(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h @%0t",
                  tag, obs, exp, $time);
      end
   endtask

   task automatic monitor();
      exp_t              e;
      logic              stall_p;
      logic [D_WIDTH+2:0] prev;
      longint            z;
      longint            d;
      stall_p = 1'b0;
      prev    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            expq.delete();
            stall_p = 1'b0;
         end else begin
            check("rdy_rule", bus.in_ready,
                  !(bus.out_valid && !bus.out_ready));
            check("ena_rule", bus.div_ena,
                  !(bus.out_valid && !bus.out_ready));
            if (stall_p)
               check("hold", {bus.out_valid, bus.out_q,
                     bus.out_dz, bus.out_ovf}, prev);
            if (!bus.out_valid)
               check("gated", {bus.out_q, bus.out_dz,
                     bus.out_ovf}, 0);
            if (bus.out_valid && bus.out_ready) begin
               if (expq.size() == 0) begin
                  check("spurious", 1, 0);
               end else begin
                  e = expq.pop_front();
                  check("q", bus.out_q, e.q);
                  check("dz", bus.out_dz, e.dz);
                  check("ovf", bus.out_ovf, e.ovf);
               end
            end
            if (bus.in_valid && bus.in_ready) begin
               z = longint'($signed(bus.in_z));
               d = longint'($signed(bus.in_d));
               expq.push_back(ref_div(z, d));
            end
            stall_p = bus.out_valid && !bus.out_ready;
            prev = {bus.out_valid, bus.out_q,
                    bus.out_dz, bus.out_ovf};
         end
      end
   endtask

   task automatic ready_drv();
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
         endcase
      end
   endtask

   task automatic push(
      input logic [Z_WIDTH-1:0] z,
      input logic [D_WIDTH-1:0] d
   );
      logic acc;
      int   t;
      bus.in_valid = 1'b1;
      bus.in_z     = z;
      bus.in_d     = d;
      t = 0;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!acc && t < 1000);
      if (!acc) check("push_to", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((expq.size() != 0 || bus.out_valid) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) check("drain_to", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic lat_test(
      input logic [Z_WIDTH-1:0] z,
      input logic [D_WIDTH-1:0] d
   );
      int cnt;
      drain();
      push(z, d);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!bus.out_valid && cnt < 100);
      check("latency", cnt, LAT);
   endtask

   task automatic reset_checks();
      check("rst_valid", bus.out_valid, 0);
      check("rst_q", bus.out_q, 0);
      check("rst_dz", bus.out_dz, 0);
      check("rst_ovf", bus.out_ovf, 0);
      check("rst_ready", bus.in_ready, 1);
      check("rst_ena", bus.div_ena, 1);
   endtask

   task automatic gen(
      output logic [Z_WIDTH-1:0] z,
      output logic [D_WIDTH-1:0] d
   );
      logic [63:0] r;
      logic [31:0] r2;
      r  = {$urandom(), $urandom()};
      r2 = $urandom();
      z  = r[Z_WIDTH-1:0];
      d  = r2[D_WIDTH-1:0];
      case ($urandom_range(0, 7))
         0: d = '0;
         1: begin
            d = D_WIDTH'($urandom_range(1, 15));
            if (r2[31]) d = -d;
         end
         2: z = r2[30] ? {1'b1, {(Z_WIDTH-1){1'b0}}}
                       : {1'b0, {(Z_WIDTH-1){1'b1}}};
         3: d = r2[30] ? Q_MIN : '1;
         default: begin
            z = $signed(z) >>> $urandom_range(0, Z_WIDTH - 2);
            d = $signed(d) >>> $urandom_range(0, D_WIDTH - 2);
         end
      endcase
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [Z_WIDTH-1:0] zb;
      logic [D_WIDTH-1:0] db;
      logic [Z_WIDTH-1:0] zs;
      logic [D_WIDTH-1:0] ds;
      int run;
      int t;

      n_tests       = 0;
      n_fail        = 0;
      ready_mode    = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_z      = '0;
      bus.in_d      = '0;
      bus.out_ready = 1'b1;
      fork
         monitor();
         ready_drv();
      join_none

      repeat (2) @(posedge clk);
      #1;
      reset_checks();
      rst = 1'b0;

      lat_test(48'sd1000, 24'sd7);
      lat_test(-48'sd1000, 24'sd7);
      lat_test(48'sd1000, -24'sd7);
      lat_test(-48'sd1000, -24'sd7);
      lat_test(48'sd5, 24'sd0);
      lat_test(-48'sd5, 24'sd0);
      lat_test(48'sd1 <<< 40, 24'sd1);
      lat_test(-(48'sd1 <<< 23), 24'sd1);
      lat_test(48'sd1 <<< 23, 24'sd1);
      drain();

      fork
         for (int i = 0; i < 30; i++) begin
            gen(zb, db);
            push(zb, db);
         end
         begin
            t = 0;
            while (!bus.out_valid && t < 200) begin
               @(negedge clk);
               t++;
            end
            run = 0;
            while (bus.out_valid && run < 100) begin
               run++;
               @(negedge clk);
            end
            check("b2b_run", run, 30);
         end
      join
      drain();

      fork
         for (int i = 0; i < 30; i++) begin
            gen(zs, ds);
            push(zs, ds);
         end
         begin
            repeat (28) @(negedge clk);
            ready_mode = 2;
            repeat (6) @(negedge clk);
            check("stall_valid", bus.out_valid, 1);
            check("stall_rdy", bus.in_ready, 0);
            check("stall_ena", bus.div_ena, 0);
            repeat (4) @(negedge clk);
            ready_mode = 0;
         end
      join
      drain();
      check("stall_left", expq.size(), 0);

      for (int i = 0; i < 12; i++) begin
         gen(zb, db);
         push(zb, db);
      end
      t = 0;
      while (!bus.out_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("pre_rst_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      reset_checks();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      lat_test(-48'sd77777, 24'sd3);
      drain();

      ready_mode = 1;
      for (int i = 0; i < 400; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         gen(zb, db);
         push(zb, db);
      end
      ready_mode = 0;
      drain();
      check("final_left", expq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
